forth_boot_loader: RTL and testbench

//  Upstream of the forth core: owns the instruction RAM and serves the core's fetch port (iaddr -> idata).

---
 rtl/forth_boot_loader.sv | 148 ++++++++++++++
 tb/tb_forth_boot_loader.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/forth_boot_loader.sv
// forth_boot_loader: owns the forth core's instruction RAM, loads a program from a byte stream, then releases the core.
// Optional feature macro LOADER_CHECKSUM_EN: a trailing checksum byte must bring the 8-bit sum of the stream to zero.
module forth_boot_loader #(
    parameter int unsigned iaddr_width = 10,
    parameter int unsigned instr_width = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [7:0]             rx_data,
    input  logic                   rx_valid,
    output logic                   rx_ready,
    input  logic [iaddr_width-1:0] iaddr,
    output logic [instr_width-1:0] idata,
    output logic                   core_reset,
    output logic                   load_done,
    output logic                   load_error,
    output logic [iaddr_width:0]   load_count
);

    localparam int unsigned depth     = 1 << iaddr_width;
    localparam int unsigned cnt_width = iaddr_width + 1;

    typedef enum logic [2:0] {
        HDR_LO,
        HDR_HI,
        DATA_LO,
        DATA_HI,
        CSUM,
        RUN,
        ERROR
    } state_t;

`ifdef LOADER_CHECKSUM_EN
    localparam state_t load_end = CSUM;
`else
    localparam state_t load_end = RUN;
`endif

    state_t                 state_q, state_d;
    logic [7:0]             count_lo_q;
    logic [15:0]            count_q;
    logic [7:0]             data_lo_q;
    logic [15:0]            hdr_count;
    logic                   accept;
    logic                   ram_we;
    logic                   last_word;
    logic [instr_width-1:0] ram [depth];

`ifdef LOADER_CHECKSUM_EN
    logic [7:0] sum_q;
    logic [7:0] sum_next;

    assign sum_next = sum_q + rx_data;

    // Running byte sum over header, data and the checksum byte itself
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sum_q <= 8'h00;
        end else if (accept) begin
            sum_q <= sum_next;
        end
    end
`endif

    assign accept    = rx_valid & rx_ready;
    assign hdr_count = {rx_data, count_lo_q};
    assign last_word = (32'(load_count) + 32'd1) >= 32'(count_q);

    // Next-state logic; every transition is gated by an accepted byte
    always_comb begin
        state_d = state_q;
        ram_we  = 1'b0;
        if (accept) begin
            case (state_q)
                HDR_LO:  state_d = HDR_HI;
                HDR_HI: begin
                    if (hdr_count == 16'h0000) begin
                        state_d = load_end;
                    end else if (32'(hdr_count) > depth) begin
                        state_d = ERROR;
                    end else begin
                        state_d = DATA_LO;
                    end
                end
                DATA_LO: state_d = DATA_HI;
                DATA_HI: begin
                    ram_we  = 1'b1;
                    state_d = last_word ? load_end : DATA_LO;
                end
`ifdef LOADER_CHECKSUM_EN
                CSUM:    state_d = (sum_next == 8'h00) ? RUN : ERROR;
`else
                CSUM:    state_d = ERROR;
`endif
                default: state_d = state_q;
            endcase
        end
    end

    // State register plus outputs registered from the next state
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= HDR_LO;
            rx_ready   <= 1'b0;
            core_reset <= 1'b1;
            load_done  <= 1'b0;
            load_error <= 1'b0;
            load_count <= '0;
            count_lo_q <= 8'h00;
            count_q    <= 16'h0000;
            data_lo_q  <= 8'h00;
        end else begin
            state_q    <= state_d;
            rx_ready   <= (state_d != RUN) && (state_d != ERROR);
            core_reset <= (state_d != RUN);
            load_done  <= (state_d == RUN);
            load_error <= (state_d == ERROR);
            if (accept && state_q == HDR_LO) begin
                count_lo_q <= rx_data;
            end
            if (accept && state_q == HDR_HI) begin
                count_q <= hdr_count;
            end
            if (accept && state_q == DATA_LO) begin
                data_lo_q <= rx_data;
            end
            if (ram_we) begin
                load_count <= load_count + cnt_width'(1);
            end
        end
    end

    // Write address is the word count; the header check keeps it below depth
    always_ff @(posedge clk) begin
        if (ram_we) begin
            ram[load_count[iaddr_width-1:0]] <= instr_width'({rx_data, data_lo_q});
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            idata <= '0;
        end else begin
            idata <= ram[iaddr];
        end
    end

endmodule

// File: tb/tb_forth_boot_loader.sv
// tb_forth_boot_loader: randomized load streams checked against a word-list model of the instruction RAM.
// Honours LOADER_CHECKSUM_EN by appending the checksum byte the stream format requires.
module tb_forth_boot_loader;

    localparam int unsigned AW    = 10;
    localparam int unsigned DEPTH = 1 << AW;

    logic          clk = 1'b0;
    logic          reset;
    logic [7:0]    rx_data;
    logic          rx_valid;
    logic          rx_ready;
    logic [AW-1:0] iaddr;
    logic [15:0]   idata;
    logic          core_reset;
    logic          load_done;
    logic          load_error;
    logic [AW:0]   load_count;

    int errors = 0;
    int checks = 0;

    logic [15:0] exp_ram [DEPTH];
    logic [15:0] words[$];
    logic [7:0]  stream[$];

    forth_boot_loader #(.iaddr_width(AW), .instr_width(16)) dut (
        .clk        (clk),
        .reset      (reset),
        .rx_data    (rx_data),
        .rx_valid   (rx_valid),
        .rx_ready   (rx_ready),
        .iaddr      (iaddr),
        .idata      (idata),
        .core_reset (core_reset),
        .load_done  (load_done),
        .load_error (load_error),
        .load_count (load_count)
    );

    always #5 clk = ~clk;

    task automatic apply_reset();
        @(posedge clk); #1;
        reset    = 1'b1;
        rx_valid = 1'b0;
        repeat (2) begin @(posedge clk); #1; end
        reset = 1'b0;
    endtask

    // Stream = count (LE), each word LE, then checksum byte if enabled
    task automatic build_stream(input int count, input bit bad_csum);
        logic [7:0] sum;
        stream.delete();
        stream.push_back(8'(count));
        stream.push_back(8'(count >> 8));
        foreach (words[i]) begin
            stream.push_back(words[i][7:0]);
            stream.push_back(words[i][15:8]);
        end
`ifdef LOADER_CHECKSUM_EN
        sum = 8'h00;
        foreach (stream[i]) sum = sum + stream[i];
        stream.push_back(8'(8'h00 - sum) + (bad_csum ? 8'h01 : 8'h00));
`else
        sum = 8'(bad_csum);
`endif
    endtask

    task automatic send_byte(input logic [7:0] b, input int max_gap);
        int waited = 0;
        repeat ($urandom_range(max_gap, 0)) begin @(posedge clk); #1; end
        rx_data  = b;
        rx_valid = 1'b1;
        while (rx_ready !== 1'b1 && waited < 50) begin
            @(posedge clk); #1;
            waited++;
        end
        checks++;
        if (rx_ready !== 1'b1) begin
            errors++;
            $display("FAIL send_timeout: rx_ready=%b required 1", rx_ready);
        end
        @(posedge clk); #1;
        rx_valid = 1'b0;
    endtask

    task automatic send_stream(input int max_gap);
        foreach (stream[i]) send_byte(stream[i], max_gap);
    endtask

    task automatic read_word(input int addr, output logic [15:0] data);
        iaddr = AW'(addr);
        @(posedge clk); #1;
        data = idata;
    endtask

    task automatic test_reset();
        @(posedge clk); #1;
        reset = 1'b1;
        #2;
        checks++; if (rx_ready !== 1'b0)   begin errors++; $display("FAIL reset_rx_ready: got %b want 0", rx_ready); end
        checks++; if (core_reset !== 1'b1) begin errors++; $display("FAIL reset_core_reset: got %b want 1", core_reset); end
        checks++; if (load_done !== 1'b0)  begin errors++; $display("FAIL reset_load_done: got %b want 0", load_done); end
        checks++; if (load_error !== 1'b0) begin errors++; $display("FAIL reset_load_error: got %b want 0", load_error); end
        checks++; if (load_count !== '0)   begin errors++; $display("FAIL reset_load_count: got %0d want 0", load_count); end
        checks++; if (idata !== 16'h0000)  begin errors++; $display("FAIL reset_idata: got %h want 0000", idata); end
        @(posedge clk); #1;
        reset = 1'b0;
        @(posedge clk); #1;
        checks++; if (rx_ready !== 1'b1) begin errors++; $display("FAIL ready_after_reset: got %b want 1", rx_ready); end
    endtask

    task automatic test_basic_load();
        logic [15:0] d;
        apply_reset();
        words = '{16'hE040, 16'h1234};
        build_stream(2, 1'b0);
        for (int i = 0; i < stream.size() - 1; i++) send_byte(stream[i], 0);
        checks++; if (core_reset !== 1'b1 || load_done !== 1'b0) begin
            errors++; $display("FAIL basic_pre_last: core_reset=%b load_done=%b want 1/0", core_reset, load_done);
        end
        send_byte(stream[stream.size() - 1], 0);
        checks++; if (load_done !== 1'b1 || core_reset !== 1'b0 || load_error !== 1'b0) begin
            errors++; $display("FAIL basic_run_edge: done=%b core_reset=%b err=%b want 1/0/0", load_done, core_reset, load_error);
        end
        checks++; if (load_count !== 11'd2) begin errors++; $display("FAIL basic_count: got %0d want 2", load_count); end
        exp_ram[0] = 16'hE040;
        exp_ram[1] = 16'h1234;
        read_word(1, d);
        checks++; if (d !== 16'h1234) begin errors++; $display("FAIL fetch_addr1: got %h want 1234", d); end
        read_word(0, d);
        checks++; if (d !== 16'hE040) begin errors++; $display("FAIL fetch_addr0: got %h want e040", d); end
    endtask

    task automatic test_zero_count();
        logic [15:0] d;
        apply_reset();
        words.delete();
        build_stream(0, 1'b0);
        send_stream(0);
        checks++; if (load_done !== 1'b1 || core_reset !== 1'b0 || load_count !== '0) begin
            errors++; $display("FAIL zero_count: done=%b core_reset=%b count=%0d want 1/0/0", load_done, core_reset, load_count);
        end
        for (int a = 0; a < 2; a++) begin
            read_word(a, d);
            checks++; if (d !== exp_ram[a]) begin errors++; $display("FAIL zero_ram_kept[%0d]: got %h want %h", a, d, exp_ram[a]); end
        end
    endtask

    task automatic test_gaps_and_run_hold();
        logic [15:0] d;
        int n;
        for (int it = 0; it < 3; it++) begin
            apply_reset();
            n = $urandom_range(16, 1);
            words.delete();
            for (int i = 0; i < n; i++) words.push_back(16'($urandom));
            build_stream(n, 1'b0);
            send_stream(5);
            foreach (words[i]) exp_ram[i] = words[i];
            checks++; if (load_done !== 1'b1 || core_reset !== 1'b0 || load_count !== 11'(n)) begin
                errors++; $display("FAIL gap_load: done=%b core_reset=%b count=%0d want 1/0/%0d", load_done, core_reset, load_count, n);
            end
            rx_valid = 1'b1;
            repeat (6) begin
                rx_data = 8'($urandom);
                @(posedge clk); #1;
                checks++; if (rx_ready !== 1'b0) begin errors++; $display("FAIL run_rx_ready: got %b want 0", rx_ready); end
            end
            rx_valid = 1'b0;
            checks++; if (load_count !== 11'(n)) begin errors++; $display("FAIL run_count_held: got %0d want %0d", load_count, n); end
            for (int a = 0; a < n; a++) begin
                read_word(a, d);
                checks++; if (d !== exp_ram[a]) begin errors++; $display("FAIL gap_ram[%0d]: got %h want %h", a, d, exp_ram[a]); end
            end
        end
    endtask

    task automatic test_oversize();
        apply_reset();
        send_byte(8'h01, 0);
        send_byte(8'h04, 0);
        checks++; if (load_error !== 1'b1 || core_reset !== 1'b1 || rx_ready !== 1'b0 || load_done !== 1'b0) begin
            errors++; $display("FAIL oversize: err=%b core_reset=%b ready=%b done=%b want 1/1/0/0", load_error, core_reset, rx_ready, load_done);
        end
        rx_valid = 1'b1;
        repeat (6) begin rx_data = 8'($urandom); @(posedge clk); #1; end
        rx_valid = 1'b0;
        checks++; if (load_error !== 1'b1 || load_count !== '0 || core_reset !== 1'b1) begin
            errors++; $display("FAIL error_terminal: err=%b count=%0d core_reset=%b want 1/0/1", load_error, load_count, core_reset);
        end
    endtask

`ifdef LOADER_CHECKSUM_EN
    task automatic test_checksum();
        apply_reset();
        words = '{16'hE040, 16'h1234};
        build_stream(2, 1'b1);
        send_stream(2);
        checks++; if (load_error !== 1'b1 || core_reset !== 1'b1 || load_done !== 1'b0) begin
            errors++; $display("FAIL bad_csum: err=%b core_reset=%b done=%b want 1/1/0", load_error, core_reset, load_done);
        end
        apply_reset();
        build_stream(2, 1'b0);
        send_stream(2);
        checks++; if (load_done !== 1'b1 || core_reset !== 1'b0 || load_error !== 1'b0) begin
            errors++; $display("FAIL good_csum: done=%b core_reset=%b err=%b want 1/0/0", load_done, core_reset, load_error);
        end
    endtask
`endif

    task automatic test_abort();
        logic [15:0] d;
        apply_reset();
        words = '{16'hBEEF, 16'h0F0F};
        build_stream(2, 1'b0);
        for (int i = 0; i < 3; i++) send_byte(stream[i], 0);
        #2 reset = 1'b1;
        #1;
        checks++; if (load_count !== '0 || core_reset !== 1'b1 || rx_ready !== 1'b0 || load_done !== 1'b0) begin
            errors++; $display("FAIL abort: count=%0d core_reset=%b ready=%b done=%b want 0/1/0/0", load_count, core_reset, rx_ready, load_done);
        end
        @(posedge clk); #1;
        reset = 1'b0;
        send_stream(1);
        foreach (words[i]) exp_ram[i] = words[i];
        checks++; if (load_done !== 1'b1 || load_count !== 11'd2) begin
            errors++; $display("FAIL abort_reload: done=%b count=%0d want 1/2", load_done, load_count);
        end
        for (int a = 0; a < 2; a++) begin
            read_word(a, d);
            checks++; if (d !== exp_ram[a]) begin errors++; $display("FAIL abort_ram[%0d]: got %h want %h", a, d, exp_ram[a]); end
        end
    endtask

    task automatic test_full_ram();
        logic [15:0] d;
        int a;
        apply_reset();
        words.delete();
        for (int i = 0; i < DEPTH; i++) words.push_back(16'($urandom));
        build_stream(DEPTH, 1'b0);
        send_stream(0);
        foreach (words[i]) exp_ram[i] = words[i];
        checks++; if (load_done !== 1'b1 || load_error !== 1'b0 || load_count !== 11'(DEPTH)) begin
            errors++; $display("FAIL full_ram: done=%b err=%b count=%0d want 1/0/%0d", load_done, load_error, load_count, DEPTH);
        end
        for (int k = 0; k < 10; k++) begin
            a = (k == 0) ? 0 : (k == 1) ? DEPTH - 1 : int'($urandom_range(DEPTH - 1, 0));
            read_word(a, d);
            checks++; if (d !== exp_ram[a]) begin errors++; $display("FAIL full_ram[%0d]: got %h want %h", a, d, exp_ram[a]); end
        end
    endtask

    initial begin
        reset    = 1'b0;
        rx_valid = 1'b0;
        rx_data  = 8'h00;
        iaddr    = '0;
        test_reset();
        test_basic_load();
        test_zero_count();
        test_gaps_and_run_hold();
        test_oversize();
`ifdef LOADER_CHECKSUM_EN
        test_checksum();
`endif
        test_abort();
        test_full_ram();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
